scan_decoder: RTL and testbench
===============================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 3, select width; SHALL be 1..6.
REQ-002 Parameter DWELL, default 4, cycles each output stays active in scan mode; SHALL be >= 1.
REQ-003 Derived OUT_W = 2**SEL_W; SHALL NOT be overridable.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 en  input  1  block enable; 0 forces all outputs low.
REQ-007 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 sel  input  SEL_W  direct-mode select / scan load index.
REQ-009 load  input  1  scan mode: one-cycle strobe, loads idx from sel.
REQ-010 dir  input  1  scan direction: 0 = up, 1 = down.
REQ-011 dout  output  OUT_W  registered one-hot decoded output.
REQ-012 idx  output  SEL_W  registered index currently decoded.
REQ-013 wrap  output  1  registered one-cycle pulse on scan wrap-around.

Function
REQ-014 States: IDLE, DIRECT, SCAN; state register SHALL be internal.
REQ-015 Transitions evaluated each edge: en=0 -> IDLE; en=1 & mode=0 -> DIRECT; en=1 & mode=1 -> SCAN; any state reachable from any state in one cycle.
REQ-016 IDLE: dout = 0, wrap = 0, idx SHALL hold last value, dwell counter cleared.
REQ-017 DIRECT: idx <= sel, dout <= one-hot(sel) with bit sel set; latency exactly 1 cycle from sel/en/mode change to dout.
REQ-018 DIRECT: wrap SHALL be 0; dwell counter held at 0.
REQ-019 Entry to SCAN from IDLE or DIRECT: first SCAN cycle SHALL decode current idx (no step), dwell counter starts at 0.
REQ-020 SCAN: dwell counter counts 0..DWELL-1; on the edge where it equals DWELL-1 it SHALL reset to 0 and idx SHALL step by +1 (dir=0) or -1 (dir=1), modulo OUT_W.
REQ-021 SCAN: dout SHALL always equal one-hot(idx) registered together with idx (never two bits set, never zero while in SCAN).
REQ-022 Wrap-around: idx OUT_W-1 -> 0 (up) or 0 -> OUT_W-1 (down) SHALL assert wrap for exactly the cycle the new idx appears; no other step asserts wrap.
REQ-023 load=1 in SCAN: idx <= sel, dwell counter <= 0, wrap <= 0; load SHALL take priority over a coincident step.
REQ-024 load SHALL be ignored outside SCAN.
REQ-025 dir change mid-dwell SHALL take effect at the next step; dwell count not disturbed.
REQ-026 DWELL=1: idx SHALL step every cycle in SCAN.
REQ-027 Arithmetic on idx SHALL be SEL_W bits, natural modulo wrap; dwell counter width SHALL be clog2(DWELL) (minimum 1).
REQ-028 All outputs SHALL be driven from registers; no combinational input-to-output path.

Reset
REQ-029 rst_n=0 at a rising edge SHALL set state IDLE, dout = 0, idx = 0, wrap = 0, dwell counter = 0, overriding en, mode, load.
REQ-030 Reset asserted mid-scan SHALL abort at the next edge; after release, SCAN restarts at idx 0 with full dwell.
REQ-031 rst_n SHALL have no effect between clock edges.

Verification
REQ-032 Direct decode, SEL_W=3: en=1, mode=0, sel=5 -> next cycle dout=8'b0010_0000, idx=5, wrap=0; sel=0 -> dout=8'b0000_0001.
REQ-033 Scan up, SEL_W=3, DWELL=4: en=1, mode=1 from reset -> idx 0 for 4 cycles, then 1,2..7 each 4 cycles; 7->0 step shows wrap=1 for one cycle, dout=8'h01.
REQ-034 Scan down with load: load=1, sel=2, dir=1 -> idx=2 next cycle; after 4 cycles 1, then 0, then 7 with wrap=1, dout=8'h80.
REQ-035 Load/step collision: load=1, sel=6 on the cycle dwell=DWELL-1 -> idx=6, dwell restarts, no step, wrap=0.
REQ-036 Enable/reset: en=0 mid-scan at idx=4 -> dout=0, idx stays 4; en=1 -> resumes at 4 with full dwell; rst_n=0 for one edge -> dout=0, idx=0, wrap=0.
REQ-037 DWELL=1, SEL_W=1: scan up -> idx toggles every cycle, dout alternates 2'b01/2'b10, wrap=1 on every 1->0 step.

Source files
------------

// File: rtl/scan_decoder_if.sv
// -----------------------------------------------------------------------------
// scan_decoder_if
// Bundles the control inputs and registered outputs of scan_decoder.
//   en    - block enable (0 forces all outputs low)
//   mode  - 0 = direct decode, 1 = auto-scan
//   sel   - direct-mode select / scan load index
//   load  - scan-mode strobe that loads idx from sel
//   dir   - scan direction, 0 = up, 1 = down
//   dout  - one-hot decoded output (OUT_W bits)
//   idx   - index currently decoded
//   wrap  - one-cycle pulse when the scan wraps around
// master: the side driving the controls; slave: the decoder itself.
// -----------------------------------------------------------------------------
interface scan_decoder_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             load;
  logic             dir;
  logic [OUT_W-1:0] dout;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, sel, load, dir,
    input  dout, idx, wrap
  );

  modport slave (
    input  en, mode, sel, load, dir,
    output dout, idx, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
// One-hot decoder with a direct mode (decode sel) and an auto-scan mode that
// walks idx up or down through all OUT_W outputs, holding each for DWELL
// cycles and pulsing wrap when the index rolls over.
// Parameters:
//   SEL_W - select width, 1..6 (must match the connected interface)
//   DWELL - cycles each output stays active while scanning, >= 1
// Ports:
//   clk   - single rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - scan_decoder_if slave modport (controls in, dout/idx/wrap out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_decoder_if.slave bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  state_t           state_q, state_nxt;
  logic [SEL_W-1:0] idx_q, idx_nxt;
  logic [OUT_W-1:0] dout_q, dout_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             wrap_q, wrap_nxt;

  // Next-state and next-output logic. The target state is chosen purely from
  // en/mode, and every output is computed for that target so a change on the
  // inputs shows up exactly one cycle later.
  always_comb begin
    state_nxt = ST_IDLE;
    idx_nxt   = idx_q;
    cnt_nxt   = '0;
    wrap_nxt  = 1'b0;
    dout_nxt  = '0;

    if (!bus.en) begin
      state_nxt = ST_IDLE;
    end else if (!bus.mode) begin
      state_nxt = ST_DIRECT;
    end else begin
      state_nxt = ST_SCAN;
    end

    case (state_nxt)
      ST_IDLE: begin
        // idx holds, everything else stays at its cleared default
      end
      ST_DIRECT: begin
        idx_nxt = bus.sel;
      end
      ST_SCAN: begin
        // The entry cycle only re-displays the current idx; load and
        // stepping are recognised once we are actually in SCAN.
        if (state_q != ST_SCAN) begin
          idx_nxt = idx_q;
        end else if (bus.load) begin
          idx_nxt = bus.sel;
        end else if (cnt_q == CNT_MAX) begin
          idx_nxt  = bus.dir ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));
          wrap_nxt = bus.dir ? (idx_q == '0) : (&idx_q);
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase

    // dout always tracks the idx being registered alongside it
    if (state_nxt != ST_IDLE) begin
      dout_nxt[idx_nxt] = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      dout_q  <= dout_nxt;
      cnt_q   <= cnt_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign bus.dout = dout_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
// Runs two decoders in lockstep: A with SEL_W=3/DWELL=4 and B with
// SEL_W=1/DWELL=1. Both are compared every cycle against a behavioural model
// that tracks how long the current index has been displayed.
// -----------------------------------------------------------------------------
module tb_scan_decoder;
  logic clk;
  logic rst_n;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  // behavioural model state, index 0 = decoder A, index 1 = decoder B
  int  out_w   [2] = '{8, 2};
  int  dwell   [2] = '{4, 1};
  int  m_idx   [2];
  int  m_dout  [2];
  int  m_wrap  [2];
  int  m_shown [2];
  bit  m_scan  [2];

  scan_decoder_if #(.SEL_W(3)) bus_a ();
  scan_decoder_if #(.SEL_W(1)) bus_b ();

  scan_decoder #(.SEL_W(3), .DWELL(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  scan_decoder #(.SEL_W(1), .DWELL(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with the expected one and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               tag, cycle, observed, expected);
    end
  endtask

  // Model of one clock edge: an index is shown for `dwell` cycles, then it
  // moves one position around a ring of out_w outputs.
  task automatic modelStep(input int k, input bit r, input bit e, input bit m,
                           input bit ld, input bit d, input int s);
    if (!r) begin
      m_scan[k]  = 0;
      m_idx[k]   = 0;
      m_wrap[k]  = 0;
      m_shown[k] = 0;
      m_dout[k]  = 0;
      return;
    end
    m_wrap[k] = 0;
    if (!e) begin
      m_scan[k]  = 0;
      m_shown[k] = 0;
      m_dout[k]  = 0;
      return;
    end
    if (!m) begin
      m_scan[k] = 0;
      m_idx[k]  = s % out_w[k];
    end else if (!m_scan[k]) begin
      m_scan[k]  = 1;
      m_shown[k] = 1;
    end else if (ld) begin
      m_idx[k]   = s % out_w[k];
      m_shown[k] = 1;
    end else if (m_shown[k] == dwell[k]) begin
      if (d) begin
        m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
        m_idx[k]  = (m_idx[k] + out_w[k] - 1) % out_w[k];
      end else begin
        m_wrap[k] = (m_idx[k] == out_w[k] - 1) ? 1 : 0;
        m_idx[k]  = (m_idx[k] + 1) % out_w[k];
      end
      m_shown[k] = 1;
    end else begin
      m_shown[k]++;
    end
    m_dout[k] = 1 << m_idx[k];
  endtask

  // Drive one cycle of inputs, advance the model and compare all outputs.
  task automatic applyStimulus(input bit r, input bit e, input bit m,
                               input bit ld, input bit d, input logic [2:0] s);
    rst_n      = r;
    bus_a.en   = e;  bus_b.en   = e;
    bus_a.mode = m;  bus_b.mode = m;
    bus_a.load = ld; bus_b.load = ld;
    bus_a.dir  = d;  bus_b.dir  = d;
    bus_a.sel  = s;  bus_b.sel  = s[0];
    @(posedge clk);
    cycle++;
    modelStep(0, r, e, m, ld, d, int'(s));
    modelStep(1, r, e, m, ld, d, int'(s[0]));
    #1;
    checkOutput("a_dout", 32'(bus_a.dout), 32'(m_dout[0]));
    checkOutput("a_idx",  32'(bus_a.idx),  32'(m_idx[0]));
    checkOutput("a_wrap", 32'(bus_a.wrap), 32'(m_wrap[0]));
    checkOutput("b_dout", 32'(bus_b.dout), 32'(m_dout[1]));
    checkOutput("b_idx",  32'(bus_b.idx),  32'(m_idx[1]));
    checkOutput("b_wrap", 32'(bus_b.wrap), 32'(m_wrap[1]));
  endtask

  initial begin
    bit e, m, ld, d, r;
    logic [2:0] s;

    // reset
    applyStimulus(0, 1, 1, 1, 0, 3'd5);
    applyStimulus(0, 0, 0, 0, 0, 3'd0);
    checkOutput("rst_dout", 32'(bus_a.dout), 32'h0);
    checkOutput("rst_idx",  32'(bus_a.idx),  32'h0);

    // direct decode
    applyStimulus(1, 1, 0, 0, 0, 3'd5);
    checkOutput("direct5_dout", 32'(bus_a.dout), 32'h20);
    checkOutput("direct5_idx",  32'(bus_a.idx),  32'h5);
    applyStimulus(1, 1, 0, 1, 0, 3'd0);
    checkOutput("direct0_dout", 32'(bus_a.dout), 32'h01);

    // scan up from reset, through the 7->0 wrap
    applyStimulus(0, 1, 1, 0, 0, 3'd0);
    for (int i = 0; i < 36; i++) applyStimulus(1, 1, 1, 0, 0, 3'd0);

    // scan down after a load of 2, through the 0->7 wrap
    applyStimulus(1, 1, 1, 1, 1, 3'd2);
    checkOutput("load2_idx", 32'(bus_a.idx), 32'h2);
    for (int i = 0; i < 14; i++) applyStimulus(1, 1, 1, 0, 1, 3'd0);

    // disable mid-scan, then resume with a full dwell
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 3'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 1, 0, 0, 3'd0);

    // load coinciding with each dwell phase, including the step edge
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 1, (i % 4) == 3, i[0], 3'd6);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      e  = ($urandom_range(0, 15) != 0);
      m  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 11) == 0);
      d  = ($urandom_range(0, 29) == 0) ? ~bus_a.dir : bus_a.dir;
      s  = 3'($urandom_range(0, 7));
      applyStimulus(r, e, m, ld, d, s);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
